// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with programmable almost thresholds, occupancy count, sticky errors and any depth >= 2.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word fall-through read data instead of the 1-cycle registered read.
module param_sync_fifo #(
    parameter int DataSize      = 3,
    parameter int Depth         = 8,
    parameter int AlmostFullTh  = 6,
    parameter int AlmostEmptyTh = 2
) (
    input  logic                       Clk,
    input  logic                       Resetn,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [DataSize-1:0]        DataIn,
    input  logic                       ErrClr,
    output logic [DataSize-1:0]        DataOut,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(Depth+1)-1:0] Count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = $clog2(Depth);

    if (AlmostFullTh < 1 || AlmostFullTh > Depth) begin : g_bad_af
        $error("param_sync_fifo: AlmostFullTh=%0d outside 1..%0d", AlmostFullTh, Depth);
    end
    if (AlmostEmptyTh < 0 || AlmostEmptyTh > Depth - 1) begin : g_bad_ae
        $error("param_sync_fifo: AlmostEmptyTh=%0d outside 0..%0d", AlmostEmptyTh, Depth - 1);
    end

    logic [DataSize-1:0] mem [Depth];
    logic [PtrW-1:0]     wptr;
    logic [PtrW-1:0]     rptr;
    logic [CntW-1:0]     count_next;
    logic                wr_ok;
    logic                rd_ok;

    // Explicit compare so non-power-of-two depths wrap at Depth-1.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A push while full is still accepted when a pop frees the head slot on the same edge.
    assign wr_ok = Push && (!full || Pop);
    assign rd_ok = Pop && !empty;

    always_comb begin
        count_next = Count;
        if (wr_ok && !rd_ok) begin
            count_next = Count + CntW'(1);
        end else if (!wr_ok && rd_ok) begin
            count_next = Count - CntW'(1);
        end
    end

    // NOTE: storage has no reset; only pointers and count define which entries are valid.
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[wptr] <= DataIn;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wptr         <= '0;
            rptr         <= '0;
            Count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) wptr <= ptr_inc(wptr);
            if (rd_ok) rptr <= ptr_inc(rptr);
            Count        <= count_next;
            full         <= (count_next == CntW'(Depth));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CntW'(AlmostFullTh));
            almost_empty <= (count_next <= CntW'(AlmostEmptyTh));
        end
    end

    // Set beats clear when both happen on one edge.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (Push && full && !Pop) overflow <= 1'b1;
            else if (ErrClr)          overflow <= 1'b0;
            if (Pop && empty)         underflow <= 1'b1;
            else if (ErrClr)          underflow <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic [PtrW-1:0] rptr_next;
    logic            head_is_new;

    assign rptr_next = rd_ok ? ptr_inc(rptr) : rptr;
    // The new head is the word being written when nothing else remains queued after this edge.
    assign head_is_new = wr_ok && ((Count == '0) || ((Count == CntW'(1)) && rd_ok));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            DataOut <= '0;
        end else if (count_next != '0) begin
            DataOut <= head_is_new ? DataIn : mem[rptr_next];
        end
    end
`else
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            DataOut <= '0;
        end else if (rd_ok) begin
            DataOut <= mem[rptr];
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: default 8-deep instance plus a 5-deep instance for non-power-of-two wrap.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       push = 0, pop = 0, err_clr = 0;
    logic [2:0] data_in = '0, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    // Instance B: Depth=5, AlmostFullTh=4, AlmostEmptyTh=1
    logic       b_push = 0, b_pop = 0, b_err_clr = 0;
    logic [3:0] b_data_in = '0, b_data_out;
    logic       b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow;
    logic [2:0] b_count;

    param_sync_fifo dut_a (
        .Clk(clk), .Resetn(rst_n), .Push(push), .Pop(pop), .DataIn(data_in), .ErrClr(err_clr),
        .DataOut(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .Count(count), .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.DataSize(4), .Depth(5), .AlmostFullTh(4), .AlmostEmptyTh(1)) dut_b (
        .Clk(clk), .Resetn(rst_n), .Push(b_push), .Pop(b_pop), .DataIn(b_data_in), .ErrClr(b_err_clr),
        .DataOut(b_data_out), .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
        .almost_empty(b_almost_empty), .Count(b_count), .overflow(b_overflow), .underflow(b_underflow)
    );

    wire [5:0] flags_a = {full, empty, almost_full, almost_empty, overflow, underflow};
    wire [5:0] flags_b = {b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow};

    int errors = 0;
    int checks = 0;

    // Reference models
    logic [2:0] sb_a[$];
    int         m_count = 0;
    logic       m_ovf = 0, m_unf = 0;
    logic [2:0] m_dout = '0;

    logic [3:0] sb_b[$];
    int         mb_count = 0;
    logic       mb_ovf = 0, mb_unf = 0;
    logic [3:0] mb_dout = '0;

    function automatic logic [5:0] exp_a();
        return {m_count == 8, m_count == 0, m_count >= 6, m_count <= 2, m_ovf, m_unf};
    endfunction

    function automatic logic [5:0] exp_b();
        return {mb_count == 5, mb_count == 0, mb_count >= 4, mb_count <= 1, mb_ovf, mb_unf};
    endfunction

    task automatic cycle_a(input logic p, input logic q, input logic [2:0] d, input logic clr);
        logic wr, rd;
        wr = p && (m_count < 8 || q);
        rd = q && (m_count > 0);
        if (p && m_count == 8 && !q) m_ovf = 1'b1;
        else if (clr)                m_ovf = 1'b0;
        if (q && m_count == 0)       m_unf = 1'b1;
        else if (clr)                m_unf = 1'b0;
        if (rd) m_dout = sb_a.pop_front();
        if (wr) sb_a.push_back(d);
        m_count = m_count + int'(wr) - int'(rd);
        push = p; pop = q; data_in = d; err_clr = clr;
        @(posedge clk); #1;
        push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic cycle_b(input logic p, input logic q, input logic [3:0] d);
        logic wr, rd;
        wr = p && (mb_count < 5 || q);
        rd = q && (mb_count > 0);
        if (p && mb_count == 5 && !q) mb_ovf = 1'b1;
        if (q && mb_count == 0)       mb_unf = 1'b1;
        if (rd) mb_dout = sb_b.pop_front();
        if (wr) sb_b.push_back(d);
        mb_count = mb_count + int'(wr) - int'(rd);
        b_push = p; b_pop = q; b_data_in = d;
        @(posedge clk); #1;
        b_push = 0; b_pop = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags_a !== 6'b010100) begin
            errors++; $display("FAIL reset_flags_a: got %b expected %b", flags_a, 6'b010100);
        end
        checks++;
        if (count !== 4'd0 || data_out !== 3'd0) begin
            errors++; $display("FAIL reset_count_data_a: got count=%0d data=%0d expected 0/0", count, data_out);
        end
        checks++;
        if (flags_b !== 6'b010100 || b_count !== 3'd0) begin
            errors++; $display("FAIL reset_b: got flags=%b count=%0d expected 010100/0", flags_b, b_count);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle_a(1'b1, 1'b0, 3'(i), 1'b0);
            checks++;
            if (count !== 4'(m_count) || flags_a !== exp_a()) begin
                errors++;
                $display("FAIL fill[%0d]: got count=%0d flags=%b expected count=%0d flags=%b",
                         i, count, flags_a, m_count, exp_a());
            end
        end
        checks++;
        if (!(full === 1'b1 && almost_full === 1'b1 && overflow === 1'b0 && count === 4'd8)) begin
            errors++; $display("FAIL fill_end: got full=%b af=%b ovf=%b count=%0d expected 1/1/0/8",
                               full, almost_full, overflow, count);
        end
    endtask

    task automatic test_overflow();
        cycle_a(1'b1, 1'b0, 3'd5, 1'b0);
        checks++;
        if (count !== 4'(m_count) || flags_a !== exp_a() || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got count=%0d flags=%b expected count=%0d flags=%b",
                               count, flags_a, m_count, exp_a());
        end
        cycle_a(1'b0, 1'b0, 3'd0, 1'b1);
        checks++;
        if (overflow !== m_ovf || count !== 4'(m_count)) begin
            errors++; $display("FAIL overflow_clear: got ovf=%b count=%0d expected ovf=%b count=%0d",
                               overflow, count, m_ovf, m_count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            cycle_a(1'b0, 1'b1, 3'd0, 1'b0);
            checks++;
            if (data_out !== m_dout || data_out !== 3'(i + 1)) begin
                errors++; $display("FAIL drain_data[%0d]: got %0d expected %0d", i, data_out, m_dout);
            end
            checks++;
            if (count !== 4'(m_count) || flags_a !== exp_a()) begin
                errors++; $display("FAIL drain_state[%0d]: got count=%0d flags=%b expected count=%0d flags=%b",
                                   i, count, flags_a, m_count, exp_a());
            end
        end
        cycle_a(1'b0, 1'b1, 3'd0, 1'b0);
        checks++;
        if (underflow !== 1'b1 || data_out !== m_dout || flags_a !== exp_a()) begin
            errors++; $display("FAIL underflow_set: got unf=%b data=%0d flags=%b expected 1/%0d/%b",
                               underflow, data_out, flags_a, m_dout, exp_a());
        end
        cycle_a(1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) cycle_a(1'b1, 1'b0, 3'(i * 3 + 2), 1'b0);
        cycle_a(1'b1, 1'b1, 3'd6, 1'b0);
        checks++;
        if (count !== 4'd8 || data_out !== m_dout || flags_a !== exp_a()) begin
            errors++; $display("FAIL simul_full: got count=%0d data=%0d flags=%b expected 8/%0d/%b",
                               count, data_out, flags_a, m_dout, exp_a());
        end
        for (int i = 0; i < 8; i++) begin
            cycle_a(1'b0, 1'b1, 3'd0, 1'b0);
            checks++;
            if (data_out !== m_dout || count !== 4'(m_count)) begin
                errors++; $display("FAIL simul_drain[%0d]: got data=%0d count=%0d expected %0d/%0d",
                                   i, data_out, count, m_dout, m_count);
            end
        end
        cycle_a(1'b1, 1'b1, 3'd4, 1'b0);
        checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || data_out !== m_dout || flags_a !== exp_a()) begin
            errors++; $display("FAIL simul_empty: got count=%0d unf=%b data=%0d expected 1/1/%0d",
                               count, underflow, data_out, m_dout);
        end
        cycle_a(1'b0, 1'b1, 3'd0, 1'b1);
        checks++;
        if (data_out !== m_dout || data_out !== 3'd4 || underflow !== m_unf) begin
            errors++; $display("FAIL simul_pop_clr: got data=%0d unf=%b expected 4/%b", data_out, underflow, m_unf);
        end
        // Pop on empty together with ErrClr: the set must win.
        cycle_a(1'b0, 1'b1, 3'd0, 1'b1);
        checks++;
        if (underflow !== 1'b1 || flags_a !== exp_a()) begin
            errors++; $display("FAIL set_wins: got unf=%b flags=%b expected 1/%b", underflow, flags_a, exp_a());
        end
        cycle_a(1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [3:0] v = 4'd1;
        for (int i = 0; i < 2; i++) begin cycle_b(1'b1, 1'b0, v); v++; end
        for (int i = 0; i < 12; i++) begin
            cycle_b(1'b1, 1'b0, v); v++;
            checks++;
            if (b_count !== 3'(mb_count) || flags_b !== exp_b()) begin
                errors++; $display("FAIL wrap_push[%0d]: got count=%0d flags=%b expected %0d/%b",
                                   i, b_count, flags_b, mb_count, exp_b());
            end
            cycle_b(1'b0, 1'b1, 4'd0);
            checks++;
            if (b_data_out !== mb_dout || b_count !== 3'(mb_count)) begin
                errors++; $display("FAIL wrap_pop[%0d]: got data=%0d count=%0d expected %0d/%0d",
                                   i, b_data_out, b_count, mb_dout, mb_count);
            end
        end
        for (int i = 0; i < 3; i++) begin cycle_b(1'b1, 1'b0, v); v++; end
        checks++;
        if (b_full !== 1'b1 || b_count !== 3'd5 || flags_b !== exp_b()) begin
            errors++; $display("FAIL wrap_full: got full=%b count=%0d flags=%b expected 1/5/%b",
                               b_full, b_count, flags_b, exp_b());
        end
        for (int i = 0; i < 5; i++) begin
            cycle_b(1'b0, 1'b1, 4'd0);
            checks++;
            if (b_data_out !== mb_dout || flags_b !== exp_b()) begin
                errors++; $display("FAIL wrap_drain[%0d]: got data=%0d flags=%b expected %0d/%b",
                                   i, b_data_out, flags_b, mb_dout, exp_b());
            end
        end
    endtask

    task automatic test_async_reset();
        cycle_a(1'b1, 1'b0, 3'd7, 1'b0);
        cycle_a(1'b1, 1'b0, 3'd6, 1'b0);
        cycle_a(1'b1, 1'b0, 3'd5, 1'b0);
        cycle_a(1'b1, 1'b0, 3'd2, 1'b0);
        cycle_a(1'b0, 1'b1, 3'd0, 1'b0);
        checks++;
        if (count !== 4'd3 || data_out !== 3'd7) begin
            errors++; $display("FAIL pre_reset: got count=%0d data=%0d expected 3/7", count, data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (flags_a !== 6'b010100 || count !== 4'd0 || data_out !== 3'd0) begin
            errors++; $display("FAIL async_reset: got flags=%b count=%0d data=%0d expected 010100/0/0",
                               flags_a, count, data_out);
        end
        sb_a.delete(); m_count = 0; m_ovf = 0; m_unf = 0; m_dout = '0;
        sb_b.delete(); mb_count = 0; mb_ovf = 0; mb_unf = 0; mb_dout = '0;
        @(negedge clk) rst_n = 1'b1;
        cycle_a(1'b1, 1'b0, 3'd3, 1'b0);
        checks++;
        if (count !== 4'd1 || flags_a !== exp_a()) begin
            errors++; $display("FAIL post_reset_push: got count=%0d flags=%b expected 1/%b", count, flags_a, exp_a());
        end
        cycle_a(1'b0, 1'b1, 3'd0, 1'b0);
        checks++;
        if (data_out !== m_dout || data_out !== 3'd3 || count !== 4'd0) begin
            errors++; $display("FAIL post_reset_pop: got data=%0d count=%0d expected 3/0", data_out, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
